// File: rtl/freq_div.sv
`default_nettype none
// freq_div: measures the InFreq period in RefClk cycles, then drives OutFreq = InFreq / 2^(n+1)
// at 50% duty, with every output edge aligned to a synchronized InFreq rise.
module freq_div #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             RefClk,
  input  logic             rst,
  input  logic             adjust,
  input  logic             InFreq,
  input  logic [2:0]       n,
  output logic             OutFreq,
  output logic             done,
  output logic [CNT_W-1:0] periodduration
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_WAIT  = 2'd1;
  localparam logic [1:0]       S_MEAS  = 2'd2;
  localparam logic [1:0]       S_RUN   = 2'd3;
  localparam logic [CNT_W-1:0] C_PMAX  = '1;
  localparam logic [CNT_W:0]   C_WDMAX = '1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_in_rise;
  logic [1:0]             r_state, w_state_nxt;
  logic [2:0]             r_n_q, w_n_q_nxt;
  logic [CNT_W-1:0]       r_pcnt, w_pcnt_nxt;
  logic [7:0]             r_ecnt, w_ecnt_nxt;
  logic [CNT_W:0]         r_wd, w_wd_nxt;
  logic                   w_out_nxt, w_done_nxt;
  logic [CNT_W-1:0]       w_pd_nxt;
  logic [7:0]             w_ecnt_max;
  logic                   w_lost;
  logic                   w_pcnt_full;

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], InFreq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_in_rise   = r_sync[SYNC_STAGES-1] & ~r_prev;
  // Terminal edge count is 2^n_q - 1, i.e. 0x7F shifted down by (7 - n_q).
  assign w_ecnt_max  = 8'h7F >> (3'd7 - r_n_q);
  assign w_lost      = r_wd > {periodduration, 1'b0};
  assign w_pcnt_full = (r_pcnt == C_PMAX);

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (adjust) begin
      w_state_nxt = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT:  if (w_in_rise) w_state_nxt = S_MEAS;
        S_MEAS: begin
          if (w_in_rise)        w_state_nxt = S_RUN;
          else if (w_pcnt_full) w_state_nxt = S_IDLE;
        end
        S_RUN:   if (!w_in_rise && w_lost) w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_n_q_nxt  = r_n_q;
    w_pcnt_nxt = r_pcnt;
    w_ecnt_nxt = r_ecnt;
    w_wd_nxt   = r_wd;
    w_out_nxt  = OutFreq;
    w_done_nxt = done;
    w_pd_nxt   = periodduration;
    if (adjust) begin
      w_n_q_nxt  = n;
      w_pcnt_nxt = '0;
      w_ecnt_nxt = '0;
      w_wd_nxt   = '0;
      w_out_nxt  = 1'b0;
      w_done_nxt = 1'b0;
    end else begin
      case (r_state)
        S_WAIT: if (w_in_rise) w_pcnt_nxt = CNT_W'(1);
        S_MEAS: begin
          if (w_in_rise) begin
            w_pd_nxt   = r_pcnt;
            w_out_nxt  = 1'b1;
            w_done_nxt = 1'b1;
            w_ecnt_nxt = '0;
            w_wd_nxt   = (CNT_W+1)'(1);
          end else if (w_pcnt_full) begin
            w_pd_nxt   = C_PMAX;
            w_done_nxt = 1'b0;
          end else begin
            w_pcnt_nxt = r_pcnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (w_in_rise) begin
            w_wd_nxt = (CNT_W+1)'(1);
            if (r_ecnt == w_ecnt_max) begin
              w_out_nxt  = ~OutFreq;
              w_ecnt_nxt = '0;
            end else begin
              w_ecnt_nxt = r_ecnt + 8'd1;
            end
          end else if (w_lost) begin
            w_out_nxt  = 1'b0;
            w_done_nxt = 1'b0;
          end else if (r_wd != C_WDMAX) begin
            w_wd_nxt = r_wd + (CNT_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge RefClk or posedge rst) begin
    if (rst) begin
      r_n_q          <= '0;
      r_pcnt         <= '0;
      r_ecnt         <= '0;
      r_wd           <= '0;
      OutFreq        <= 1'b0;
      done           <= 1'b0;
      periodduration <= '0;
    end else begin
      r_n_q          <= w_n_q_nxt;
      r_pcnt         <= w_pcnt_nxt;
      r_ecnt         <= w_ecnt_nxt;
      r_wd           <= w_wd_nxt;
      OutFreq        <= w_out_nxt;
      done           <= w_done_nxt;
      periodduration <= w_pd_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_freq_div.sv
`default_nettype none
`timescale 1ps/1ps
// tb_freq_div: directed scenarios plus randomized input periods, checked every cycle against an
// event-level model built from input-rise timestamps.
module tb_freq_div;

  localparam int CNT_W = 16;
  localparam int S     = 2;

  logic             RefClk = 1'b0;
  logic             rst    = 1'b1;
  logic             adjust = 1'b0;
  logic             InFreq = 1'b0;
  logic [2:0]       n      = 3'd0;
  logic             OutFreq;
  logic             done;
  logic [CNT_W-1:0] periodduration;

  freq_div #(.CNT_W(CNT_W), .SYNC_STAGES(S)) dut (
    .RefClk(RefClk), .rst(rst), .adjust(adjust), .InFreq(InFreq), .n(n),
    .OutFreq(OutFreq), .done(done), .periodduration(periodduration)
  );

  always #3333 RefClk = ~RefClk;

  int    checks = 0;
  int    errors = 0;
  string tag    = "init";

  // Model: input samples per edge, rise timestamps and the expected outputs.
  bit samp[$];
  int cyc, rises, t0, last_rise, pd, nlat;
  bit armed, e_out, e_done;

  task automatic model_reset();
    samp.delete();
    for (int i = 0; i < S + 2; i++) samp.push_back(1'b0);
    armed = 0; rises = 0; t0 = 0; last_rise = 0; pd = 0; nlat = 0;
    e_out = 0; e_done = 0;
  endtask

  task automatic model_edge();
    bit rise;
    cyc++;
    if (rst) begin
      model_reset();
      return;
    end
    samp.push_front(InFreq);
    void'(samp.pop_back());
    rise = samp[S] && !samp[S+1];
    if (adjust) begin
      armed = 1; rises = 0; nlat = int'(n); e_out = 0; e_done = 0;
    end else if (armed) begin
      if (rise) begin
        if (rises == 0) begin
          t0 = cyc; rises = 1;
        end else begin
          if (rises == 1) pd = cyc - t0;
          rises++;
          last_rise = cyc;
          e_done = 1;
          e_out = !(((rises - 2) >> nlat) & 1);
        end
      end else if (rises == 1 && (cyc - t0) == 65535) begin
        pd = 65535; armed = 0;
      end else if (rises >= 2 && (cyc - last_rise) > 2 * pd) begin
        armed = 0; e_out = 0; e_done = 0;
      end
    end
  endtask

  task automatic check_outputs();
    checks++;
    assert (OutFreq === e_out) else begin
      errors++; $error("FAIL %s OutFreq observed=%0b expected=%0b", tag, OutFreq, e_out);
    end
    checks++;
    assert (done === e_done) else begin
      errors++; $error("FAIL %s done observed=%0b expected=%0b", tag, done, e_done);
    end
    checks++;
    assert (periodduration === CNT_W'(pd)) else begin
      errors++; $error("FAIL %s periodduration observed=%0d expected=%0d", tag, periodduration, pd);
    end
  endtask

  task automatic step();
    @(posedge RefClk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic do_adjust(input logic [2:0] nv);
    n = nv; adjust = 1'b1;
    step();
    adjust = 1'b0;
  endtask

  task automatic wave(input int period, input int high, input int nrise);
    for (int r = 0; r < nrise; r++) begin
      InFreq = 1'b1;
      repeat (high) step();
      InFreq = 1'b0;
      repeat (period - high) step();
    end
  endtask

  initial begin
    int p, h, nv;
    model_reset();
    cyc = 0;

    // Reset held ~30 ns while InFreq toggles.
    tag = "reset";
    for (int i = 0; i < 10; i++) begin
      #3000 InFreq = ~InFreq;
      check_outputs();
    end
    InFreq = 1'b0;
    rst = 1'b0;
    tag = "reset_release";
    repeat (3) step();

    tag = "basic_n2";
    do_adjust(3'd2);
    wave(150, 75, 12);
    checks++;
    assert (periodduration >= 149 && periodduration <= 151) else begin
      errors++; $error("FAIL basic_pd_range observed=%0d expected=149..151", periodduration);
    end

    tag = "ratio_n0";
    do_adjust(3'd0);
    wave(150, 75, 6);

    tag = "ratio_n7";
    p = $urandom_range(8, 12);
    h = $urandom_range(1, p - 1);
    do_adjust(3'd7);
    wave(p, h, 2 + 512 + 1);

    tag = "restart";
    do_adjust(3'd2);
    wave(150, 75, 6);
    n = 3'd1;
    wave(150, 75, 6);
    do_adjust(3'd1);
    wave(150, 75, 8);

    tag = "loss";
    do_adjust(3'd1);
    wave(150, 75, 4);
    repeat (330) step();
    checks++;
    assert (done === 1'b0 && OutFreq === 1'b0) else begin
      errors++; $error("FAIL loss_final observed done=%0b out=%0b expected 0/0", done, OutFreq);
    end

    for (int k = 0; k < 6; k++) begin
      tag = $sformatf("random_%0d", k);
      p  = $urandom_range(6, 60);
      h  = $urandom_range(1, p - 1);
      nv = $urandom_range(0, 3);
      do_adjust(3'(nv));
      wave(p, h, 2 + (1 << (nv + 2)));
    end

    tag = "timeout";
    do_adjust(3'd3);
    InFreq = 1'b1;
    repeat (5) step();
    InFreq = 1'b0;
    repeat (65545) step();
    checks++;
    assert (periodduration === 16'hFFFF && done === 1'b0) else begin
      errors++; $error("FAIL timeout_final observed pd=%0h done=%0b expected ffff/0", periodduration, done);
    end

    tag = "mid_measure_rst";
    do_adjust(3'd3);
    InFreq = 1'b1;
    repeat (5) step();
    InFreq = 1'b0;
    repeat (100) step();
    #2000 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    #500 rst = 1'b0;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
